// File: rtl/dau_sym_parser_pkg.sv
// Typed views of the shared DAU encodings used by the symbol parser.
package dau_sym_parser_pkg;
`include "dau_defs.vh"

  localparam int unsigned SYM_W = `DAU_SYM_WIDTH;
  localparam int unsigned CMD_W = 3;

  typedef logic [SYM_W-1:0] sym_t;

  localparam sym_t SYM_DIGIT_MAX = `DAU_SYM_DIGIT_MAX;
  localparam sym_t SYM_COMMA     = `DAU_SYM_COMMA;
  localparam sym_t SYM_PLUS      = `DAU_SYM_PLUS;
  localparam sym_t SYM_MINUS     = `DAU_SYM_MINUS;
  localparam sym_t SYM_MUL       = `DAU_SYM_MUL;
  localparam sym_t SYM_DIV       = `DAU_SYM_DIV;
  localparam sym_t SYM_RESULT    = `DAU_SYM_RESULT;
  localparam sym_t SYM_SEP       = `DAU_SYM_SEPARATOR;
  localparam sym_t SYM_RESET     = `DAU_SYM_RESET;
  localparam sym_t SYM_INVALID   = `DAU_SYM_INVALID;

  localparam logic [CMD_W-1:0] CMD_ADD    = `DAU_CMD_ADD;
  localparam logic [CMD_W-1:0] CMD_SUB    = `DAU_CMD_SUB;
  localparam logic [CMD_W-1:0] CMD_MUL    = `DAU_CMD_MUL;
  localparam logic [CMD_W-1:0] CMD_DIV    = `DAU_CMD_DIV;
  localparam logic [CMD_W-1:0] CMD_RESULT = `DAU_CMD_RESULT;
  localparam logic [CMD_W-1:0] CMD_RESET  = `DAU_CMD_RESET;

  localparam logic [3:0] BCD_NINE = 4'h9;

  typedef enum logic [2:0] {
    ST_IDLE  = `DAU_ST_IDLE,
    ST_SIGN  = `DAU_ST_SIGN,
    ST_INT   = `DAU_ST_INT,
    ST_FRAC  = `DAU_ST_FRAC,
    ST_EMIT  = `DAU_ST_EMIT,
    ST_ERROR = `DAU_ST_ERROR
  } state_e;

  function automatic logic is_digit(input sym_t s);
    return s <= SYM_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/dau_defs.vh
// Shared symbol, command and state encodings for the DAU calculator front end.
`ifndef DAU_DEFS_VH
`define DAU_DEFS_VH

`define DAU_SYM_WIDTH     5
`define DAU_SYM_DIGIT_MAX 5'd9
`define DAU_SYM_COMMA     5'd10
`define DAU_SYM_PLUS      5'd11
`define DAU_SYM_MINUS     5'd12
`define DAU_SYM_MUL       5'd13
`define DAU_SYM_DIV       5'd14
`define DAU_SYM_RESULT    5'd15
`define DAU_SYM_SEPARATOR 5'd16
`define DAU_SYM_RESET     5'd17
`define DAU_SYM_INVALID   5'd31

`define DAU_CMD_ADD       3'd0
`define DAU_CMD_SUB       3'd1
`define DAU_CMD_MUL       3'd2
`define DAU_CMD_DIV       3'd3
`define DAU_CMD_RESULT    3'd4
`define DAU_CMD_RESET     3'd5

`define DAU_ST_IDLE       3'd0
`define DAU_ST_SIGN       3'd1
`define DAU_ST_INT        3'd2
`define DAU_ST_FRAC       3'd3
`define DAU_ST_EMIT       3'd4
`define DAU_ST_ERROR      3'd5

`endif

// File: rtl/dau_sym_parser_accum.sv
// BCD digit accumulator: integer shift-in, fraction slot writes, overflow/zero detect.
// DAU_PARSE_SAT_EN: integer overflow saturates the whole magnitude to 9s instead of flagging.
module dau_bcd_accum
  import dau_sym_parser_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 10,
  parameter int unsigned FRAC_DIGITS = 6
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    int_shift_i,
  input  logic                    frac_wr_i,
  input  logic [3:0]              digit_i,
  output logic [4*NUM_DIGITS-1:0] mag_c,
  output logic                    inexact_o,
  output logic                    int_full_c,
  output logic                    zero_c
);

  localparam int unsigned INT_DIGITS = NUM_DIGITS - FRAC_DIGITS;
  localparam int unsigned IW         = 4 * INT_DIGITS;
  localparam int unsigned FW         = 4 * FRAC_DIGITS;
  localparam int unsigned CNT_W      = $clog2(NUM_DIGITS + 1);

  logic [IW-1:0]    int_q, int_d;
  logic [FW-1:0]    frac_q, frac_d;
  logic [CNT_W-1:0] sig_cnt_q, sig_cnt_d;
  logic [CNT_W-1:0] frac_cnt_q, frac_cnt_d;
  logic             inexact_q, inexact_d;
`ifdef DAU_PARSE_SAT_EN
  logic             sat_q, sat_d;
`endif

  assign int_full_c = (sig_cnt_q == CNT_W'(INT_DIGITS));
  assign zero_c     = ({int_q, frac_q} == '0);
  assign inexact_o  = inexact_q;
`ifdef DAU_PARSE_SAT_EN
  assign mag_c = sat_q ? {NUM_DIGITS{BCD_NINE}} : {int_q, frac_q};
`else
  assign mag_c = {int_q, frac_q};
`endif

  always_comb begin
    int_d      = int_q;
    frac_d     = frac_q;
    sig_cnt_d  = sig_cnt_q;
    frac_cnt_d = frac_cnt_q;
    inexact_d  = inexact_q;
`ifdef DAU_PARSE_SAT_EN
    sat_d      = sat_q;
`endif
    if (clr_i) begin
      int_d      = '0;
      frac_d     = '0;
      sig_cnt_d  = '0;
      frac_cnt_d = '0;
      inexact_d  = 1'b0;
`ifdef DAU_PARSE_SAT_EN
      sat_d      = 1'b0;
`endif
    end else if (int_shift_i) begin
      if (int_full_c) begin
`ifdef DAU_PARSE_SAT_EN
        sat_d     = 1'b1;
        inexact_d = 1'b1;
`else
        inexact_d = inexact_q;
`endif
      end else if ((sig_cnt_q != '0) || (digit_i != 4'h0)) begin
        // leading zeros neither shift nor consume an integer slot
        int_d     = (int_q << 4) | IW'(digit_i);
        sig_cnt_d = sig_cnt_q + CNT_W'(1);
      end
    end else if (frac_wr_i) begin
      if (frac_cnt_q < CNT_W'(FRAC_DIGITS)) begin
        for (int unsigned i = 0; i < FRAC_DIGITS; i++) begin
          if (frac_cnt_q == CNT_W'(FRAC_DIGITS - 1 - i)) frac_d[4*i +: 4] = digit_i;
        end
        frac_cnt_d = frac_cnt_q + CNT_W'(1);
      end else begin
        inexact_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      int_q      <= '0;
      frac_q     <= '0;
      sig_cnt_q  <= '0;
      frac_cnt_q <= '0;
      inexact_q  <= 1'b0;
`ifdef DAU_PARSE_SAT_EN
      sat_q      <= 1'b0;
`endif
    end else begin
      int_q      <= int_d;
      frac_q     <= frac_d;
      sig_cnt_q  <= sig_cnt_d;
      frac_cnt_q <= frac_cnt_d;
      inexact_q  <= inexact_d;
`ifdef DAU_PARSE_SAT_EN
      sat_q      <= sat_d;
`endif
    end
  end

endmodule

// File: rtl/dau_sym_parser.sv
// RPN calculator tokenizer: symbol stream in, number/command tokens out.
// DAU_PARSE_SAT_EN: integer overflow saturates instead of entering ERROR.
module dau_sym_parser
  import dau_sym_parser_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 10,
  parameter int unsigned FRAC_DIGITS = 6
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  input  logic [SYM_W-1:0]        i_symbol,
  output logic                    o_ready,
  output logic                    o_tok_valid,
  input  logic                    i_tok_ready,
  output logic                    o_tok_is_num,
  output logic [CMD_W-1:0]        o_tok_cmd,
  output logic                    o_sign,
  output logic [4*NUM_DIGITS-1:0] o_mag,
  output logic                    o_inexact,
  output logic                    o_error
);

  localparam int unsigned MAG_W = 4 * NUM_DIGITS;
`ifdef DAU_PARSE_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  state_e             state_q, state_d;
  logic               sign_q, sign_d;
  logic               ready_q, ready_d;
  logic               error_q, error_d;
  logic               tok_valid_q, tok_valid_d;
  logic               tok_is_num_q, tok_is_num_d;
  logic [CMD_W-1:0]   tok_cmd_q, tok_cmd_d;
  logic               tok_sign_q, tok_sign_d;
  logic [MAG_W-1:0]   tok_mag_q, tok_mag_d;
  logic               tok_inexact_q, tok_inexact_d;

  logic               acc_clr, acc_int_shift, acc_frac_wr;
  logic [MAG_W-1:0]   acc_mag_c;
  logic               acc_inexact, acc_int_full_c, acc_zero_c;

  logic               accept_c, hs_c, dig_c;
  logic               emit_num_c, emit_cmd_c;
  logic [CMD_W-1:0]   cmd_c;

  dau_bcd_accum #(
    .NUM_DIGITS  (NUM_DIGITS),
    .FRAC_DIGITS (FRAC_DIGITS)
  ) u_accum (
    .clk_i       (i_clk),
    .rst_i       (i_rst),
    .clr_i       (acc_clr),
    .int_shift_i (acc_int_shift),
    .frac_wr_i   (acc_frac_wr),
    .digit_i     (i_symbol[3:0]),
    .mag_c       (acc_mag_c),
    .inexact_o   (acc_inexact),
    .int_full_c  (acc_int_full_c),
    .zero_c      (acc_zero_c)
  );

  assign accept_c = i_valid && ready_q && (i_symbol != SYM_INVALID);
  assign hs_c     = tok_valid_q && i_tok_ready;
  assign dig_c    = is_digit(i_symbol);

  always_comb begin
    state_d       = state_q;
    sign_d        = sign_q;
    tok_valid_d   = tok_valid_q;
    tok_is_num_d  = tok_is_num_q;
    tok_cmd_d     = tok_cmd_q;
    tok_sign_d    = tok_sign_q;
    tok_mag_d     = tok_mag_q;
    tok_inexact_d = tok_inexact_q;
    acc_clr       = 1'b0;
    acc_int_shift = 1'b0;
    acc_frac_wr   = 1'b0;
    emit_num_c    = 1'b0;
    emit_cmd_c    = 1'b0;
    cmd_c         = CMD_ADD;

    if (hs_c) begin
      tok_valid_d = 1'b0;
      state_d     = ST_IDLE;
      sign_d      = 1'b0;
      acc_clr     = 1'b1;
    end

    if (accept_c) begin
      if (i_symbol == SYM_RESET) begin
        acc_clr    = 1'b1;
        sign_d     = 1'b0;
        emit_cmd_c = 1'b1;
        cmd_c      = CMD_RESET;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (dig_c) begin
              state_d       = ST_INT;
              acc_int_shift = 1'b1;
            end else begin
              case (i_symbol)
                SYM_MINUS:  state_d = ST_SIGN;
                SYM_COMMA:  state_d = ST_FRAC;
                SYM_PLUS:   begin emit_cmd_c = 1'b1; cmd_c = CMD_ADD;    end
                SYM_MUL:    begin emit_cmd_c = 1'b1; cmd_c = CMD_MUL;    end
                SYM_DIV:    begin emit_cmd_c = 1'b1; cmd_c = CMD_DIV;    end
                SYM_RESULT: begin emit_cmd_c = 1'b1; cmd_c = CMD_RESULT; end
                default:    state_d = state_q;
              endcase
            end
          end
          ST_SIGN: begin
            if (dig_c) begin
              state_d       = ST_INT;
              sign_d        = 1'b1;
              acc_int_shift = 1'b1;
            end else begin
              case (i_symbol)
                SYM_COMMA: begin state_d = ST_FRAC; sign_d = 1'b1; end
                SYM_SEP:   begin emit_cmd_c = 1'b1; cmd_c = CMD_SUB; end
                SYM_PLUS, SYM_MINUS, SYM_MUL, SYM_DIV, SYM_RESULT: state_d = ST_ERROR;
                default:   state_d = state_q;
              endcase
            end
          end
          ST_INT, ST_FRAC: begin
            if (dig_c) begin
              acc_int_shift = (state_q == ST_INT);
              acc_frac_wr   = (state_q == ST_FRAC);
              if ((state_q == ST_INT) && acc_int_full_c && !SAT_EN) state_d = ST_ERROR;
            end else begin
              case (i_symbol)
                SYM_COMMA: state_d = (state_q == ST_INT) ? ST_FRAC : ST_ERROR;
                SYM_SEP:   emit_num_c = 1'b1;
                SYM_PLUS, SYM_MINUS, SYM_MUL, SYM_DIV, SYM_RESULT: state_d = ST_ERROR;
                default:   state_d = state_q;
              endcase
            end
          end
          default: state_d = state_q;
        endcase
      end
    end

    // token payload is captured here so it stays frozen through EMIT
    if (emit_num_c || emit_cmd_c) begin
      state_d       = ST_EMIT;
      tok_valid_d   = 1'b1;
      tok_is_num_d  = emit_num_c;
      tok_cmd_d     = emit_num_c ? CMD_ADD : cmd_c;
      tok_sign_d    = emit_num_c && sign_q && !acc_zero_c;
      tok_mag_d     = emit_num_c ? acc_mag_c : '0;
      tok_inexact_d = emit_num_c && acc_inexact;
    end

    ready_d = (state_d != ST_EMIT);
    error_d = (state_d == ST_ERROR);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      sign_q        <= 1'b0;
      ready_q       <= 1'b1;
      error_q       <= 1'b0;
      tok_valid_q   <= 1'b0;
      tok_is_num_q  <= 1'b0;
      tok_cmd_q     <= '0;
      tok_sign_q    <= 1'b0;
      tok_mag_q     <= '0;
      tok_inexact_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sign_q        <= sign_d;
      ready_q       <= ready_d;
      error_q       <= error_d;
      tok_valid_q   <= tok_valid_d;
      tok_is_num_q  <= tok_is_num_d;
      tok_cmd_q     <= tok_cmd_d;
      tok_sign_q    <= tok_sign_d;
      tok_mag_q     <= tok_mag_d;
      tok_inexact_q <= tok_inexact_d;
    end
  end

  assign o_ready      = ready_q;
  assign o_error      = error_q;
  assign o_tok_valid  = tok_valid_q;
  assign o_tok_is_num = tok_is_num_q;
  assign o_tok_cmd    = tok_cmd_q;
  assign o_sign       = tok_sign_q;
  assign o_mag        = tok_mag_q;
  assign o_inexact    = tok_inexact_q;

endmodule

// File: tb/tb_dau_sym_parser.sv
// Scoreboard bench for dau_sym_parser (NUM_DIGITS=10, FRAC_DIGITS=6); honours DAU_PARSE_SAT_EN.
module tb_dau_sym_parser;
  import dau_sym_parser_pkg::*;

  typedef struct packed {
    logic        is_num;
    logic [2:0]  cmd;
    logic        sign;
    logic [39:0] mag;
    logic        inexact;
  } tok_t;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic [SYM_W-1:0] i_symbol;
  logic        o_ready;
  logic        o_tok_valid;
  logic        i_tok_ready;
  logic        o_tok_is_num;
  logic [2:0]  o_tok_cmd;
  logic        o_sign;
  logic [39:0] o_mag;
  logic        o_inexact;
  logic        o_error;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;
  tok_t exp_q[$];

  dau_sym_parser #(.NUM_DIGITS(10), .FRAC_DIGITS(6)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .i_symbol     (i_symbol),
    .o_ready      (o_ready),
    .o_tok_valid  (o_tok_valid),
    .i_tok_ready  (i_tok_ready),
    .o_tok_is_num (o_tok_is_num),
    .o_tok_cmd    (o_tok_cmd),
    .o_sign       (o_sign),
    .o_mag        (o_mag),
    .o_inexact    (o_inexact),
    .o_error      (o_error)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_num(input logic s, input logic [39:0] m, input logic inx);
    exp_q.push_back({1'b1, 3'd0, s, m, inx});
  endtask

  task automatic exp_cmd(input logic [2:0] c);
    exp_q.push_back({1'b0, c, 1'b0, 40'h0, 1'b0});
  endtask

  function automatic sym_t ch2sym(input byte c);
    case (c)
      "-":     return SYM_MINUS;
      ",":     return SYM_COMMA;
      "+":     return SYM_PLUS;
      "*":     return SYM_MUL;
      "/":     return SYM_DIV;
      "=":     return SYM_RESULT;
      "S":     return SYM_SEP;
      "R":     return SYM_RESET;
      default: begin
        if (c >= "0" && c <= "9") return sym_t'(c - "0");
        return SYM_INVALID;
      end
    endcase
  endfunction

  // Called and returns at posedge+1; presents one symbol until it is accepted.
  task automatic send(input sym_t s);
    int n;
    n = 0;
    i_valid  = 1'b1;
    i_symbol = s;
    @(negedge i_clk);
    while (!o_ready && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: got o_ready=0 expected 1 for symbol %0d", s);
    end
    @(posedge i_clk);
    #1;
    i_valid  = 1'b0;
    i_symbol = SYM_INVALID;
  endtask

  task automatic send_str(input string str);
    for (int i = 0; i < str.len(); i++) send(ch2sym(str[i]));
  endtask

  initial begin
    i_rst       = 1'b1;
    i_valid     = 1'b0;
    i_symbol    = SYM_INVALID;
    i_tok_ready = 1'b1;
    @(negedge i_clk);
    check("reset_ctl", 64'({o_ready, o_tok_valid, o_tok_is_num, o_tok_cmd, o_sign, o_inexact, o_error}),
          64'(9'b1_0_0_000_0_0_0));
    check("reset_mag", 64'(o_mag), 64'h0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    fork
      begin : monitor
        tok_t act, exp;
        while (!done) begin
          @(negedge i_clk);
          if (o_tok_valid && i_tok_ready) begin
            act = {o_tok_is_num, o_tok_cmd, o_sign, o_mag, o_inexact};
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_token: got %0h expected none", act);
            end else begin
              exp = exp_q.pop_front();
              check("token", 64'(act), 64'(exp));
            end
          end
        end
      end
      begin : stimulus
        // 1: negative mixed number, token one cycle after SEP
        exp_num(1'b1, 40'h0012345678, 1'b0);
        send_str("-12,345678S");
        @(negedge i_clk);
        check("latency_valid", 64'(o_tok_valid), 64'h1);
        @(posedge i_clk);
        #1;

        // 2: fraction truncation, then bare minus as SUB
        exp_num(1'b0, 40'h0000567899, 1'b1);
        send_str(",56789912S");
        exp_cmd(CMD_SUB);
        send_str("-S");

        // 3: integer overflow
`ifdef DAU_PARSE_SAT_EN
        exp_num(1'b0, 40'h9999999999, 1'b1);
        send_str("12345S");
        @(negedge i_clk);
        check("sat_no_error", 64'(o_error), 64'h0);
        @(posedge i_clk);
        #1;
`else
        send_str("12345");
        @(negedge i_clk);
        check("ovf_error", 64'(o_error), 64'h1);
        @(posedge i_clk);
        #1;
        send_str("678+S");
        @(negedge i_clk);
        check("error_sticky", 64'(o_error), 64'h1);
        @(posedge i_clk);
        #1;
`endif
        exp_cmd(CMD_RESET);
        send_str("R");
        @(negedge i_clk);
        check("reset_clears_err", 64'(o_error), 64'h0);
        @(posedge i_clk);
        #1;

        // 4: backpressure holds the token and blocks input
        i_tok_ready = 1'b0;
        exp_num(1'b0, 40'h0007000000, 1'b0);
        send_str("7S");
        for (int c = 0; c < 5; c++) begin
          i_valid  = 1'b1;
          i_symbol = (c % 2 == 0) ? SYM_SEP : SYM_INVALID;
          @(negedge i_clk);
          check("bp_valid", 64'(o_tok_valid), 64'h1);
          check("bp_ready", 64'(o_ready), 64'h0);
          check("bp_mag", 64'(o_mag), 64'h0007000000);
          @(posedge i_clk);
          #1;
        end
        i_valid     = 1'b0;
        i_symbol    = SYM_INVALID;
        i_tok_ready = 1'b1;

        // 5: negative zero, double comma, recovery with extra separators
        exp_num(1'b0, 40'h0, 1'b0);
        send_str("-0,0S");
        send_str("1,2,3");
        @(negedge i_clk);
        check("comma2_error", 64'(o_error), 64'h1);
        @(posedge i_clk);
        #1;
        exp_cmd(CMD_RESET);
        exp_num(1'b0, 40'h0005000000, 1'b0);
        exp_cmd(CMD_MUL);
        send_str("R5SSS*");
        repeat (2) @(posedge i_clk);
        #1;

        // 6: asynchronous reset mid-number
        send_str("3,1");
        #1;
        i_rst = 1'b1;
        #1;
        check("arst_ctl", 64'({o_ready, o_tok_valid, o_tok_is_num, o_tok_cmd, o_sign, o_inexact, o_error}),
              64'(9'b1_0_0_000_0_0_0));
        check("arst_mag", 64'(o_mag), 64'h0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        exp_num(1'b0, 40'h0002000000, 1'b0);
        send_str("2S");

        repeat (4) @(negedge i_clk);
        check("queue_drained", 64'(exp_q.size()), 64'h0);
        done = 1'b1;
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dau_sym_parser.md
Name: dau_sym_parser

Overview:
- Front-end tokenizer for the RPN decimal calculator.
- Consumes the `DAU_SYM_* symbol stream one symbol per handshake.
- Assembles sign-magnitude fixed-point BCD operands and emits them as tokens; operator and control symbols are emitted as command tokens.
- Sits between the keypad/UART symbol source and the operand stack / ALU; generalises the existing fixed-format entry logic to configurable integer/fraction split.

Parameters:
- NUM_DIGITS, 10: total BCD digits of magnitude (integer + fraction); valid range 2..16.
- FRAC_DIGITS, 6: digits after the comma; valid range 1..NUM_DIGITS-1. Integer digits INT_DIGITS = NUM_DIGITS-FRAC_DIGITS.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  symbol valid.
- i_symbol  in  `DAU_SYM_WIDTH  input symbol.
- o_ready  out  1  parser accepts a symbol this cycle.
- o_tok_valid  out  1  token pending.
- i_tok_ready  in  1  downstream accepts token.
- o_tok_is_num  out  1  1 = number token, 0 = command token.
- o_tok_cmd  out  3  command code: ADD, SUB, MUL, DIV, RESULT, RESET.
- o_sign  out  1  number sign, 1 = negative.
- o_mag  out  4*NUM_DIGITS  BCD magnitude; lowest FRAC_DIGITS nibbles are the fraction.
- o_inexact  out  1  fraction digits beyond FRAC_DIGITS were dropped; qualifies number token.
- o_error  out  1  parser in ERROR state.

Behaviour:
- Reset values: o_ready=1, o_tok_valid=0, o_tok_is_num=0, o_tok_cmd=0, o_sign=0, o_mag=0, o_inexact=0, o_error=0; state IDLE.
- A symbol is accepted on a rising edge with i_valid && o_ready. `DAU_SYM_INVALID is accepted and ignored in every state.
- States: IDLE, SIGN, INT, FRAC, EMIT, ERROR.
- o_ready=1 in IDLE, SIGN, INT, FRAC and ERROR; o_ready=0 in EMIT.
- IDLE:
  - digit -> INT, digit loaded.
  - MINUS -> SIGN.
  - COMMA -> FRAC.
  - PLUS / MUL / DIV / RESULT -> EMIT with the matching command.
  - SEPARATOR -> ignored.
- SIGN (sign resolution):
  - digit -> INT with sign=1.
  - COMMA -> FRAC with sign=1.
  - SEPARATOR -> EMIT command SUB.
  - any other operator -> ERROR.
- INT:
  - Digit shifts into the integer field.
  - Leading zeros are not counted.
  - A significant digit beyond INT_DIGITS -> ERROR.
  - COMMA -> FRAC.
- FRAC:
  - Digit k (1-based) is written to fraction nibble FRAC_DIGITS-k.
  - For k > FRAC_DIGITS the digit is dropped and inexact is set (sticky until emit).
  - A second COMMA -> ERROR.
- INT/FRAC:
  - SEPARATOR -> EMIT number token.
  - PLUS / MUL / DIV / MINUS -> ERROR.
- Negative zero is normalised to sign=0 at emit. A bare "," or "-," yields magnitude 0.
- EMIT:
  - Token outputs are registered and become visible the cycle after the terminating symbol is accepted (1-cycle latency).
  - Outputs are held stable while o_tok_valid && !i_tok_ready.
  - On handshake: accumulator, sign and inexact clear, state -> IDLE, o_ready=1 the following cycle.
- RESET symbol, in any state other than EMIT:
  - Clears the accumulator and error.
  - Goes to EMIT with command RESET.
- ERROR: o_error=1. All symbols except RESET are accepted and discarded.
- i_rst mid-token: everything returns to reset values immediately; any pending token is lost.

Optional Feature:
- Macro: DAU_PARSE_SAT_EN.
- Defined: integer overflow does not enter ERROR. The integer field saturates to all 9s and the fraction is forced to all 9s at emit. Further digits are dropped, o_inexact=1, and parsing continues normally.
- Undefined: overflow -> ERROR as above.

Decomposition:
- Shared header dau_defs.vh holds:
  - the `DAU_SYM_* symbol codes and `DAU_SYM_WIDTH;
  - the command code constants `DAU_CMD_ADD/SUB/MUL/DIV/RESULT/RESET;
  - the state encodings.
- One sub-module: dau_bcd_accum, the digit accumulator. It handles integer shift, fraction slot write, leading-zero/significant-digit counting, saturation and zero detection. The top module holds the FSM and token register.

Test Plan (NUM_DIGITS=10, FRAC_DIGITS=6; i_tok_ready=1 unless stated):
1. "-12,345678" SEP -> one number token: sign=1, o_mag=40'h0012345678, inexact=0, one cycle after SEP.
2. ",56789912" SEP -> o_mag=40'h0000567899, inexact=1. Then "-" SEP -> command token SUB.
3. "12345" -> o_error=1 and further digits ignored. RESET -> command RESET, o_error=0. With DAU_PARSE_SAT_EN instead: "12345" SEP -> o_mag=40'h9999999999, inexact=1.
4. Backpressure on "7" SEP with i_tok_ready=0 for 5 cycles -> o_tok_valid held, o_ready=0, payload stable; SEP/INVALID symbols presented meanwhile are not consumed.
5. "-0,0" SEP -> sign=0, mag=0. Then "1,2,3" -> ERROR on the second comma. Then "5" SEP SEP SEP MUL -> after the RESET recovery step: one number token 5 (40'h0005000000) and one command token MUL; the extra separators produce no tokens.
6. i_rst asserted asynchronously mid-"3,1" -> all outputs at reset values within the same cycle. "2" SEP after release -> mag=40'h0002000000.
